// File: rtl/leds_lab2_if.sv
// leds_lab2_if: switch inputs and LED/segment/anode outputs of the Lab 2 block.
//   switch1 [3:0]  first operand, shown on digit 0
//   switch2 [3:0]  second operand, shown on digit 1
//   leds    [4:0]  sum switch1 + switch2
//   seg     [6:0]  {g,f,e,d,c,b,a}, active-low
//   anode   [1:0]  digit enables, active-low
// master: the board/switch side (drives switches, observes outputs).
// slave : the leds_lab2 block.
interface leds_lab2_if;
    logic [3:0] switch1;
    logic [3:0] switch2;
    logic [4:0] leds;
    logic [6:0] seg;
    logic [1:0] anode;

    modport master (
        output switch1,
        output switch2,
        input  leds,
        input  seg,
        input  anode
    );

    modport slave (
        input  switch1,
        input  switch2,
        output leds,
        output seg,
        output anode
    );
endinterface

// File: rtl/leds_lab2.sv
// leds_lab2: adds two 4-bit switch values onto five LEDs and shows both
// values in hex on a time-multiplexed pair of common-anode 7-segment digits.
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous, active-low
//   bus    leds_lab2_if.slave (switch1, switch2, leds, seg, anode)
// Parameter:
//   REFRESH_DIV  clk cycles per digit slot (minimum 2)
// Build option:
//   LEDS_REG_EN  when defined, leds is registered (1-cycle latency, cleared
//                by reset); otherwise leds is purely combinational.
module leds_lab2 #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    leds_lab2_if.slave  bus
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          sel_reg;
    logic          sel_next;
    logic          act_reg;
    logic [4:0]    sum_next;
    logic [3:0]    nibble;
    logic [6:0]    hex_code;

    assign sum_next = {1'b0, bus.switch1} + {1'b0, bus.switch2};

`ifdef LEDS_REG_EN
    logic [4:0] leds_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            leds_reg <= 5'b00000;
        end else begin
            leds_reg <= sum_next;
        end
    end

    assign bus.leds = leds_reg;
`else
    assign bus.leds = sum_next;
`endif

    // The counter holds at 0 on the edge that raises act, so the first slot
    // after release lasts a full REFRESH_DIV cycles like every later slot.
    always_comb begin
        cnt_next = cnt_reg;
        sel_next = sel_reg;
        if (act_reg) begin
            if (cnt_reg == CNT_LAST) begin
                cnt_next = '0;
                sel_next = ~sel_reg;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_reg <= '0;
            sel_reg <= 1'b0;
            act_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            sel_reg <= sel_next;
            act_reg <= 1'b1;
        end
    end

    // Digit gi is lit only when active and selected; at most one is ever low.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_anode
            assign bus.anode[gi] = ~(act_reg && (sel_reg == gi[0]));
        end
    endgenerate

    assign nibble = sel_reg ? bus.switch2 : bus.switch1;

    always_comb begin
        hex_code = 7'b1111111;
        case (nibble)
            4'h0: hex_code = 7'b1000000;
            4'h1: hex_code = 7'b1111001;
            4'h2: hex_code = 7'b0100100;
            4'h3: hex_code = 7'b0110000;
            4'h4: hex_code = 7'b0011001;
            4'h5: hex_code = 7'b0010010;
            4'h6: hex_code = 7'b0000010;
            4'h7: hex_code = 7'b1111000;
            4'h8: hex_code = 7'b0000000;
            4'h9: hex_code = 7'b0010000;
            4'hA: hex_code = 7'b0001000;
            4'hB: hex_code = 7'b0000011;
            4'hC: hex_code = 7'b1000110;
            4'hD: hex_code = 7'b0100001;
            4'hE: hex_code = 7'b0000110;
            4'hF: hex_code = 7'b0001110;
            default: hex_code = 7'b1111111;
        endcase
    end

    assign bus.seg = act_reg ? hex_code : 7'b1111111;

endmodule

// File: tb/tb_leds_lab2.sv
// tb_leds_lab2: scoreboard bench for leds_lab2 with REFRESH_DIV=4.
// The driver applies one vector per cycle and queues the expected
// {leds, seg, anode}; a monitor on the falling edge pops and compares.
// Honours LEDS_REG_EN for the expected leds timing.
module tb_leds_lab2;

    typedef struct packed {
        logic [4:0] leds;
        logic [6:0] seg;
        logic [1:0] anode;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    leds_lab2_if bus ();

    leds_lab2 #(.REFRESH_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    int   k      = 0;        // rising edges with reset high since last reset edge
    logic [4:0] last_sum = 5'd0;
    logic [4:0] reg_leds = 5'd0;

    task automatic drive(input logic r, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        logic [4:0] s;
        @(posedge clk);
        if (reset == 1'b0) k = 0;
        else k = k + 1;
        reg_leds = reset ? last_sum : 5'd0;
        #1;
        reset = r;
        bus.switch1 = a;
        bus.switch2 = b;
        s = {1'b0, a} + {1'b0, b};
`ifdef LEDS_REG_EN
        e.leds = reg_leds;
`else
        e.leds = s;
`endif
        if (k == 0) begin
            e.anode = 2'b11;
            e.seg   = 7'b1111111;
        end else if ((((k - 1) / 4) % 2) == 0) begin
            e.anode = 2'b10;
            e.seg   = hex_tab[a];
        end else begin
            e.anode = 2'b01;
            e.seg   = hex_tab[b];
        end
        exp_q.push_back(e);
        last_sum = s;
    endtask

    task automatic chk(input string name, input int act_v, input int exp_v);
        checks++;
        if (act_v != exp_v) begin
            errors++;
            $display("FAIL %s txn %0d got %b want %b", name, txn, act_v, exp_v);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("leds",  int'(bus.leds),  int'(e.leds));
            chk("seg",   int'(bus.seg),   int'(e.seg));
            chk("anode", int'(bus.anode), int'(e.anode));
            $display("txn %0d sw1=%h sw2=%h leds=%b seg=%b anode=%b",
                     txn, bus.switch1, bus.switch2, bus.leds, bus.seg, bus.anode);
            txn++;
        end
    end

    initial begin
        int wait_cycles;
        bus.switch1 = 4'h0;
        bus.switch2 = 4'h0;
        // Reset held: outputs dark, leds still tracks the switches.
        drive(1'b0, 4'h3, 4'h4);
        drive(1'b0, 4'hF, 4'hF);
        drive(1'b0, 4'h8, 4'h8);
        // Release on the next edge.
        drive(1'b1, 4'h7, 4'h9);
        // A + 3 across one full 10/01 period.
        for (int i = 0; i < 8; i++) drive(1'b1, 4'hA, 4'h3);
        // Switch1 changes mid-slot while digit 0 is lit.
        drive(1'b1, 4'hA, 4'h3);
        drive(1'b1, 4'hA, 4'h3);
        drive(1'b1, 4'h5, 4'h3);
        drive(1'b1, 4'h5, 4'h6);
        drive(1'b1, 4'h5, 4'h6);
        drive(1'b1, 4'h5, 4'h6);
        // k is now 15: sel=1, cnt=2. Pulse reset for one edge.
        drive(1'b0, 4'h5, 4'h6);
        drive(1'b1, 4'h0, 4'h0);
        // Exhaustive sweep; also exercises the restart window and alternation.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            drive(1'b1, v[7:4], v[3:0]);
        end
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        chk("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
